// File: rtl/ex_pkg.sv
// Shared op-codes, FSM encoding and multiply step count for the execute stage.
package ex_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_MULT = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int MUL_STEPS = 32;
  localparam int CNT_W     = $clog2(MUL_STEPS);

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier: low DW bits of the product, MUL_STEPS edges after start.
// done is combinational and flags the cycle whose closing edge performs the last step.
module seq_multiplier
  import ex_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] mcand_i,
  input  logic [DW-1:0] mplier_i,
  output logic          done,
  output logic [DW-1:0] product
);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    mcand_q;
  logic [DW-1:0]    mplier_q;
  logic [DW-1:0]    prod_q;
  logic [DW-1:0]    prod_d;

  always_comb begin
    prod_d  = prod_q + (mplier_q[0] ? mcand_q : '0);
    done    = busy_q && (cnt_q == CNT_W'(MUL_STEPS - 1));
    product = prod_d;
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else if (abort) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      prod_q   <= '0;
    end else if (busy_q) begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-edge ALU/shift ops, 32-edge iterative MULT with registered stall.
// Upstream must hold ID/EX while stall=1; flush kills the presented or in-flight op.
module ex_stage
  import ex_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  input  logic [3:0]    op,
  input  logic          reg_dst,
  input  logic          reg_write,
  input  logic [DW-1:0] dato_A,
  input  logic [DW-1:0] dato_B,
  input  logic [4:0]    shampt,
  input  logic [4:0]    rd,
  input  logic [4:0]    rt,
  input  logic          flush,
  output logic          stall,
  output logic          valid_out,
  output logic          reg_write_out,
  output logic [DW-1:0] result_out,
  output logic [4:0]    dest_out
);

  state_e        state_q, state_d;
  logic [DW-1:0] alu_res;
  logic [4:0]    dest_sel;
  logic          mul_start, mul_abort, mul_done;
  logic [DW-1:0] mul_product;
  logic [4:0]    mul_dest_q, mul_dest_d;
  logic          mul_rw_q, mul_rw_d;
  logic          valid_q, valid_d;
  logic          rw_q, rw_d;
  logic [DW-1:0] result_q, result_d;
  logic [4:0]    dest_q, dest_d;
  logic          stall_q;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = dato_A + dato_B;
      OP_SUB:  alu_res = dato_A - dato_B;
      OP_AND:  alu_res = dato_A & dato_B;
      OP_OR:   alu_res = dato_A | dato_B;
      OP_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(dato_A) < $signed(dato_B))};
      OP_SLL:  alu_res = dato_B << shampt;
      OP_SRL:  alu_res = dato_B >> shampt;
      OP_SRA:  alu_res = $signed(dato_B) >>> shampt;
      default: alu_res = '0;
    endcase
  end

  assign dest_sel  = reg_dst ? rd : rt;
  assign mul_start = (state_q == ST_IDLE) && valid_in && (op == OP_MULT) && !flush;
  assign mul_abort = (state_q == ST_BUSY) && flush;

  seq_multiplier #(.DW(DW)) u_mul (
    .clk      (clk),
    .reset    (reset),
    .start    (mul_start),
    .abort    (mul_abort),
    .mcand_i  (dato_A),
    .mplier_i (dato_B),
    .done     (mul_done),
    .product  (mul_product)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_BUSY;
      ST_BUSY: if (flush || mul_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Result/dest hold when nothing retires; reg_write_out is always qualified by valid.
  always_comb begin
    valid_d    = 1'b0;
    rw_d       = 1'b0;
    result_d   = result_q;
    dest_d     = dest_q;
    mul_dest_d = mul_dest_q;
    mul_rw_d   = mul_rw_q;
    case (state_q)
      ST_IDLE: begin
        if (mul_start) begin
          mul_dest_d = dest_sel;
          mul_rw_d   = reg_write;
        end else if (valid_in && !flush) begin
          valid_d  = 1'b1;
          rw_d     = reg_write;
          result_d = alu_res;
          dest_d   = dest_sel;
        end
      end
      ST_BUSY: begin
        if (!flush && mul_done) begin
          valid_d  = 1'b1;
          rw_d     = mul_rw_q;
          result_d = mul_product;
          dest_d   = mul_dest_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(negedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      rw_q       <= 1'b0;
      result_q   <= '0;
      dest_q     <= '0;
      mul_dest_q <= '0;
      mul_rw_q   <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rw_q       <= rw_d;
      result_q   <= result_d;
      dest_q     <= dest_d;
      mul_dest_q <= mul_dest_d;
      mul_rw_q   <= mul_rw_d;
      stall_q    <= (state_d == ST_BUSY);
    end
  end

  assign stall         = stall_q;
  assign valid_out     = valid_q;
  assign reg_write_out = rw_q;
  assign result_out    = result_q;
  assign dest_out      = dest_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: random and directed ops checked against an arithmetic model.
`timescale 1ns/1ps
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset, valid_in, reg_dst, reg_write, flush;
  logic [3:0]  op;
  logic [31:0] dato_A, dato_B;
  logic [4:0]  shampt, rd, rt;
  logic        stall, valid_out, reg_write_out;
  logic [31:0] result_out;
  logic [4:0]  dest_out;

  ex_stage #(.DW(32)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .op(op), .reg_dst(reg_dst),
    .reg_write(reg_write), .dato_A(dato_A), .dato_B(dato_B), .shampt(shampt),
    .rd(rd), .rt(rt), .flush(flush), .stall(stall), .valid_out(valid_out),
    .reg_write_out(reg_write_out), .result_out(result_out), .dest_out(dest_out)
  );

  // Active edge is the falling edge at t = 10*k; edge index k.
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    logic        rw;
    int          at_edge;
  } exp_t;

  exp_t sb[$];
  exp_t dummy;
  int   checks = 0;
  int   fails = 0;
  int   busy_start = -1;
  int   busy_end = -1;
  bit   mon_en = 1'b0;

  function automatic int edge_now();
    return int'($time / 10);
  endfunction

  function automatic logic [31:0] ref_res(input int o, input logic [31:0] a, input logic [31:0] b,
                                          input int sh);
    case (o)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5: return b << sh;
      6: return b >> sh;
      7: return 32'($signed(b) >>> sh);
      8: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, edge_now());
    end
  endtask

  task automatic drive(input int o, input logic [31:0] a, input logic [31:0] b, input int sh,
                       input int rdv, input int rtv, input bit rdst, input bit rw);
    op = 4'(o); dato_A = a; dato_B = b; shampt = 5'(sh);
    rd = 5'(rdv); rt = 5'(rtv); reg_dst = rdst; reg_write = rw;
  endtask

  // Present an op and hold it frozen while stall is high, as ID/EX would.
  task automatic issue(input int o, input logic [31:0] a, input logic [31:0] b, input int sh,
                       input int rdv, input int rtv, input bit rdst, input bit rw);
    logic s;
    int   guard = 0;
    exp_t e;
    @(posedge clk);
    drive(o, a, b, sh, rdv, rtv, rdst, rw);
    valid_in = 1'b1; flush = 1'b0;
    s = stall;
    @(negedge clk);
    while (s && guard < 100) begin
      @(posedge clk);
      s = stall;
      @(negedge clk);
      guard++;
    end
    if (s) begin
      checks++; fails++;
      $display("FAIL issue_timeout: stall still 1 after %0d edges, required 0", guard);
    end else begin
      e.res  = ref_res(o, a, b, sh);
      e.dest = rdst ? 5'(rdv) : 5'(rtv);
      e.rw   = rw;
      e.at_edge = (o == 8) ? edge_now() + 32 : edge_now();
      if (o == 8) begin
        busy_start = edge_now();
        busy_end   = edge_now() + 32;
      end
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    valid_in = 1'b0; flush = 1'b0;
    @(negedge clk);
  endtask

  // Flush in IDLE kills the presented instruction; skipped while a multiply is running.
  task automatic flush_idle();
    @(posedge clk);
    if (stall) begin
      valid_in = 1'b0; flush = 1'b0;
    end else begin
      drive($urandom_range(0, 15), $urandom, $urandom, $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom), 1'($urandom));
      valid_in = 1'b1; flush = 1'b1;
    end
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (mon_en) begin
      chk("stall", {31'd0, stall},
          {31'd0, (edge_now() >= busy_start) && (edge_now() < busy_end)});
      if (valid_out) begin
        if (sb.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_output: result %h dest %0d, required no output", result_out, dest_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", result_out, e.res);
          chk("dest", {27'd0, dest_out}, {27'd0, e.dest});
          chk("reg_write", {31'd0, reg_write_out}, {31'd0, e.rw});
          chk("latency_edge", edge_now(), e.at_edge);
        end
      end
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
    chk({tag, "_rw"}, {31'd0, reg_write_out}, 32'd0);
    chk({tag, "_result"}, result_out, 32'd0);
    chk({tag, "_dest"}, {27'd0, dest_out}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    reset = 1'b0;
    chk_zero_outputs("reset");
    mon_en = 1'b1;

    issue(0, 32'hFFFF_FFFF, 32'h0000_0002, 0, 5, 1, 1'b1, 1'b1);
    issue(4, 32'hFFFF_FFFE, 32'h0000_0001, 0, 6, 2, 1'b1, 1'b1);
    issue(7, 32'h0, 32'h8000_0000, 4, 7, 3, 1'b1, 1'b0);
    issue(6, 32'h0, 32'h8000_0000, 4, 8, 4, 1'b0, 1'b1);
    issue(12, 32'h1234, 32'h5678, 0, 9, 10, 1'b1, 1'b1);

    issue(8, 32'h0001_2345, 32'h0000_0100, 0, 1, 9, 1'b0, 1'b1);
    issue(0, 32'd3, 32'd4, 0, 11, 12, 1'b1, 1'b1);
    issue(8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 13, 14, 1'b1, 1'b1);
    issue(8, 32'h0000_0007, 32'h0000_0006, 0, 15, 16, 1'b1, 1'b0);
    repeat (3) idle();

    // Flush on the 10th BUSY edge.
    issue(8, 32'h1234_5678, 32'h9ABC_DEF0, 0, 17, 18, 1'b1, 1'b1);
    repeat (9) idle();
    @(posedge clk);
    valid_in = 1'b0; flush = 1'b1;
    @(negedge clk);
    busy_end = edge_now();
    dummy = sb.pop_back();
    @(posedge clk);
    flush = 1'b0;
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_valid", {31'd0, valid_out}, 32'd0);
    repeat (40) idle();

    // Reset in the middle of a multiply.
    issue(8, 32'h0000_0003, 32'h0000_0005, 0, 19, 20, 1'b1, 1'b1);
    repeat (5) idle();
    @(posedge clk);
    reset = 1'b1; valid_in = 1'b0;
    @(negedge clk);
    busy_end = edge_now();
    dummy = sb.pop_back();
    @(posedge clk);
    reset = 1'b0;
    chk_zero_outputs("midmul_reset");
    issue(0, 32'd1, 32'd1, 0, 21, 22, 1'b1, 1'b1);
    repeat (40) idle();

    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) idle();
      else if (r == 1) flush_idle();
      else issue($urandom_range(0, 15), $urandom, $urandom, $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 100 && sb.size() != 0; i++) idle();
    repeat (2) idle();
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
